cmult_rr_scheduler: RTL and testbench

- Shares one complex_multiplier instance between NUM_CH AXI-Stream requesters using round-robin arbitration.
- Each request is an (a,b) operand pair. Results return on a single stream with the originating channel number in tuser.
- A tag FIFO tracks the channel of each in-flight request. An outstanding-request counter bounds the number of in-flight requests so tags never overflow.
- Sits between the requester fabric and the multiplier's s_axis_a/s_axis_b/m_axis_dout ports.

---
 rtl/cmult_rr_scheduler_if.sv | 60 ++++++
 rtl/cmult_rr_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_cmult_rr_scheduler.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cmult_rr_scheduler_if.sv
// Stream bundle between the requester fabric, the shared complex multiplier and the
// round-robin scheduler. The scheduler uses the slave view; the environment drives the master view.
interface cmult_rr_scheduler_if #(
    parameter int NUM_CH         = 4,
    parameter int PORT_WIDTH_A   = 32,
    parameter int PORT_WIDTH_B   = 32,
    parameter int PORT_WIDTH_OUT = 64,
    parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    // Requester side: one operand pair slot per channel
    logic [NUM_CH*PORT_WIDTH_A-1:0] s_axis_a_tdata;
    logic [NUM_CH*PORT_WIDTH_B-1:0] s_axis_b_tdata;
    logic [NUM_CH-1:0]              s_axis_tvalid;
    logic [NUM_CH-1:0]              s_axis_tready;

    // Operand streams toward the multiplier
    logic [PORT_WIDTH_A-1:0]        m_mult_a_tdata;
    logic                           m_mult_a_tvalid;
    logic                           m_mult_a_tready;
    logic [PORT_WIDTH_B-1:0]        m_mult_b_tdata;
    logic                           m_mult_b_tvalid;
    logic                           m_mult_b_tready;

    // Result stream from the multiplier
    logic [PORT_WIDTH_OUT-1:0]      s_mult_dout_tdata;
    logic                           s_mult_dout_tvalid;
    logic                           s_mult_dout_tready;

    // Tagged result stream back to the requesters
    logic [PORT_WIDTH_OUT-1:0]      m_axis_dout_tdata;
    logic [CH_W-1:0]                m_axis_dout_tuser;
    logic                           m_axis_dout_tvalid;
    logic                           m_axis_dout_tready;

    modport slave (
        input  s_axis_a_tdata, s_axis_b_tdata, s_axis_tvalid,
        output s_axis_tready,
        output m_mult_a_tdata, m_mult_a_tvalid,
        input  m_mult_a_tready,
        output m_mult_b_tdata, m_mult_b_tvalid,
        input  m_mult_b_tready,
        input  s_mult_dout_tdata, s_mult_dout_tvalid,
        output s_mult_dout_tready,
        output m_axis_dout_tdata, m_axis_dout_tuser, m_axis_dout_tvalid,
        input  m_axis_dout_tready
    );

    modport master (
        output s_axis_a_tdata, s_axis_b_tdata, s_axis_tvalid,
        input  s_axis_tready,
        input  m_mult_a_tdata, m_mult_a_tvalid,
        output m_mult_a_tready,
        input  m_mult_b_tdata, m_mult_b_tvalid,
        output m_mult_b_tready,
        output s_mult_dout_tdata, s_mult_dout_tvalid,
        input  s_mult_dout_tready,
        input  m_axis_dout_tdata, m_axis_dout_tuser, m_axis_dout_tvalid,
        output m_axis_dout_tready
    );
endinterface

// File: rtl/cmult_rr_scheduler.sv
// Round-robin sharing of one complex multiplier between NUM_CH requesters; a tag FIFO
// remembers the channel of each in-flight pair so in-order results can be labelled.
module cmult_rr_scheduler #(
    parameter int  NUM_CH          = 4,
    parameter int  PORT_WIDTH_A    = 32,
    parameter int  PORT_WIDTH_B    = 32,
    parameter int  PORT_WIDTH_OUT  = 64,
    parameter int  MAX_OUTSTANDING = 8,
    localparam int CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int OCW             = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    cmult_rr_scheduler_if.slave   bus,
    output logic [OCW-1:0]        outstanding,
    output logic                  err_orphan
);

    localparam int              TAG_AW  = $clog2(MAX_OUTSTANDING);
    localparam int              PW      = TAG_AW + 1;
    localparam logic [OCW-1:0]  MAX_CNT = OCW'(MAX_OUTSTANDING);

    // Registered state
    logic                       en_q;
    logic                       a_pend_q, a_pend_d;
    logic                       b_pend_q, b_pend_d;
    logic [PORT_WIDTH_A-1:0]    a_q, a_d;
    logic [PORT_WIDTH_B-1:0]    b_q, b_d;
    logic [CH_W-1:0]            rr_q, rr_d;
    logic [OCW-1:0]             cnt_q, cnt_d;
    logic                       err_q, err_d;
    logic [CH_W-1:0]            tag_mem_q [MAX_OUTSTANDING];
    logic [CH_W-1:0]            tag_mem_d [MAX_OUTSTANDING];
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic                       dout_valid_q, dout_valid_d;
    logic [PORT_WIDTH_OUT-1:0]  dout_data_q, dout_data_d;
    logic [CH_W-1:0]            dout_user_q, dout_user_d;

    // Combinational handshake / grant terms
    logic                       a_hs_s, b_hs_s, issue_free_s;
    logic                       gnt_any_s;
    logic [CH_W-1:0]            gnt_ch_s;
    logic [NUM_CH-1:0]          gnt_vec_s;
    logic                       dout_ready_s, res_hs_s, tag_empty_s;
    logic                       retire_s, orphan_s;

    // Handshake decode; readiness is held low until the first clock after reset release
    always_comb begin
        a_hs_s       = a_pend_q && bus.m_mult_a_tready;
        b_hs_s       = b_pend_q && bus.m_mult_b_tready;
        issue_free_s = !(a_pend_q && !a_hs_s) && !(b_pend_q && !b_hs_s);
        dout_ready_s = en_q && (!dout_valid_q || bus.m_axis_dout_tready);
        res_hs_s     = bus.s_mult_dout_tvalid && dout_ready_s;
        tag_empty_s  = (wr_ptr_q == rd_ptr_q);
        retire_s     = res_hs_s && !tag_empty_s;
        orphan_s     = res_hs_s && tag_empty_s;
    end

    // Round-robin search starting at rr_q; the count is compared as registered
    always_comb begin
        int idx;
        idx       = 0;
        gnt_any_s = 1'b0;
        gnt_ch_s  = CH_W'(0);
        gnt_vec_s = {NUM_CH{1'b0}};
        if (en_q && issue_free_s && (cnt_q < MAX_CNT)) begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_CH) begin
                    idx = idx - NUM_CH;
                end else begin
                    idx = idx;
                end
                if (!gnt_any_s && bus.s_axis_tvalid[idx]) begin
                    gnt_any_s = 1'b1;
                    gnt_ch_s  = CH_W'(idx);
                end else begin
                    gnt_any_s = gnt_any_s;
                end
            end
        end else begin
            gnt_any_s = 1'b0;
        end
        if (gnt_any_s) begin
            gnt_vec_s[gnt_ch_s] = 1'b1;
        end else begin
            gnt_vec_s = {NUM_CH{1'b0}};
        end
    end

    // Issue register, rr pointer and tag push
    always_comb begin
        a_pend_d  = a_pend_q && !a_hs_s;
        b_pend_d  = b_pend_q && !b_hs_s;
        a_d       = a_q;
        b_d       = b_q;
        rr_d      = rr_q;
        wr_ptr_d  = wr_ptr_q;
        tag_mem_d = tag_mem_q;
        if (gnt_any_s) begin
            a_pend_d  = 1'b1;
            b_pend_d  = 1'b1;
            a_d       = bus.s_axis_a_tdata[gnt_ch_s*PORT_WIDTH_A +: PORT_WIDTH_A];
            b_d       = bus.s_axis_b_tdata[gnt_ch_s*PORT_WIDTH_B +: PORT_WIDTH_B];
            tag_mem_d[wr_ptr_q[TAG_AW-1:0]] = gnt_ch_s;
            wr_ptr_d  = wr_ptr_q + PW'(1);
            if (gnt_ch_s == CH_W'(NUM_CH - 1)) begin
                rr_d = CH_W'(0);
            end else begin
                rr_d = gnt_ch_s + CH_W'(1);
            end
        end else begin
            rr_d = rr_q;
        end
    end

    // Outstanding counter, tag pop, output register and orphan flag
    always_comb begin
        cnt_d        = cnt_q;
        rd_ptr_d     = rd_ptr_q;
        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;
        dout_user_d  = dout_user_q;
        err_d        = err_q || orphan_s;
        case ({gnt_any_s, retire_s})
            2'b10:   cnt_d = cnt_q + OCW'(1);
            2'b01:   cnt_d = cnt_q - OCW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (retire_s) begin
            rd_ptr_d     = rd_ptr_q + PW'(1);
            dout_valid_d = 1'b1;
            dout_data_d  = bus.s_mult_dout_tdata;
            dout_user_d  = tag_mem_q[rd_ptr_q[TAG_AW-1:0]];
        end else if (bus.m_axis_dout_tready) begin
            dout_valid_d = 1'b0;
        end else begin
            dout_valid_d = dout_valid_q;
        end
    end

    // State registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            en_q         <= 1'b0;
            a_pend_q     <= 1'b0;
            b_pend_q     <= 1'b0;
            a_q          <= {PORT_WIDTH_A{1'b0}};
            b_q          <= {PORT_WIDTH_B{1'b0}};
            rr_q         <= CH_W'(0);
            cnt_q        <= OCW'(0);
            err_q        <= 1'b0;
            tag_mem_q    <= '{default: CH_W'(0)};
            wr_ptr_q     <= PW'(0);
            rd_ptr_q     <= PW'(0);
            dout_valid_q <= 1'b0;
            dout_data_q  <= {PORT_WIDTH_OUT{1'b0}};
            dout_user_q  <= CH_W'(0);
        end else begin
            en_q         <= 1'b1;
            a_pend_q     <= a_pend_d;
            b_pend_q     <= b_pend_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            tag_mem_q    <= tag_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            dout_user_q  <= dout_user_d;
        end
    end

    assign bus.s_axis_tready      = gnt_vec_s;
    assign bus.m_mult_a_tdata     = a_q;
    assign bus.m_mult_a_tvalid    = a_pend_q;
    assign bus.m_mult_b_tdata     = b_q;
    assign bus.m_mult_b_tvalid    = b_pend_q;
    assign bus.s_mult_dout_tready = dout_ready_s;
    assign bus.m_axis_dout_tdata  = dout_data_q;
    assign bus.m_axis_dout_tuser  = dout_user_q;
    assign bus.m_axis_dout_tvalid = dout_valid_q;
    assign outstanding            = cnt_q;
    assign err_orphan             = err_q;

endmodule

// File: tb/tb_cmult_rr_scheduler.sv
// Directed bench for cmult_rr_scheduler; the bench itself plays the multiplier and downstream sink.
module tb_cmult_rr_scheduler;

    logic       aclk;
    logic       aresetn;
    logic [3:0] outstanding;
    logic       err_orphan;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] a_of [4];
    logic [31:0] b_of [4];
    int          seq2 [5];
    int          seq3 [2];
    logic [3:0]  exp_vec;

    cmult_rr_scheduler_if #(
        .NUM_CH(4), .PORT_WIDTH_A(32), .PORT_WIDTH_B(32), .PORT_WIDTH_OUT(64)
    ) bus ();

    cmult_rr_scheduler #(
        .NUM_CH(4), .PORT_WIDTH_A(32), .PORT_WIDTH_B(32),
        .PORT_WIDTH_OUT(64), .MAX_OUTSTANDING(8)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .bus         (bus),
        .outstanding (outstanding),
        .err_orphan  (err_orphan)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        a_of[0] = 32'h0001_0010; a_of[1] = 32'h0002_0003;
        a_of[2] = 32'h0003_0012; a_of[3] = 32'h0004_0013;
        b_of[0] = 32'h0101_0001; b_of[1] = 32'h0001_0004;
        b_of[2] = 32'h0103_0001; b_of[3] = 32'h0104_0001;
        seq2 = '{2, 3, 0, 1, 2};
        seq3 = '{3, 0};

        bus.s_axis_a_tdata     = {a_of[3], a_of[2], a_of[1], a_of[0]};
        bus.s_axis_b_tdata     = {b_of[3], b_of[2], b_of[1], b_of[0]};
        bus.s_axis_tvalid      = 4'b0010;
        bus.m_mult_a_tready    = 1'b1;
        bus.m_mult_b_tready    = 1'b1;
        bus.s_mult_dout_tdata  = 64'h0;
        bus.s_mult_dout_tvalid = 1'b0;
        bus.m_axis_dout_tready = 1'b1;
        aresetn                = 1'b0;
        tick();
        tick();

        // Reset state, with a request already pending on channel 1
        chk("rst_tready",      64'(bus.s_axis_tready),      64'h0);
        chk("rst_a_valid",     64'(bus.m_mult_a_tvalid),    64'h0);
        chk("rst_b_valid",     64'(bus.m_mult_b_tvalid),    64'h0);
        chk("rst_dout_valid",  64'(bus.m_axis_dout_tvalid), 64'h0);
        chk("rst_mdout_ready", 64'(bus.s_mult_dout_tready), 64'h0);
        chk("rst_outstanding", 64'(outstanding),            64'h0);
        chk("rst_err",         64'(err_orphan),             64'h0);

        // Single channel-1 request: (3+2j)*(4+1j) = 10+11j
        aresetn = 1'b1;
        tick();
        chk("t1_grant", 64'(bus.s_axis_tready), 64'h2);
        chk("t1_out0",  64'(outstanding),       64'h0);
        tick();
        bus.s_axis_tvalid = 4'b0000;
        chk("t1_a_valid", 64'(bus.m_mult_a_tvalid), 64'h1);
        chk("t1_a_data",  64'(bus.m_mult_a_tdata),  64'h0002_0003);
        chk("t1_b_valid", 64'(bus.m_mult_b_tvalid), 64'h1);
        chk("t1_b_data",  64'(bus.m_mult_b_tdata),  64'h0001_0004);
        chk("t1_out1",    64'(outstanding),         64'h1);
        tick();
        chk("t1_a_done", 64'(bus.m_mult_a_tvalid), 64'h0);
        chk("t1_b_done", 64'(bus.m_mult_b_tvalid), 64'h0);
        tick(); tick(); tick(); tick();
        bus.s_mult_dout_tdata  = 64'h0000_000B_0000_000A;
        bus.s_mult_dout_tvalid = 1'b1;
        #1;
        chk("t1_mdout_ready", 64'(bus.s_mult_dout_tready), 64'h1);
        tick();
        bus.s_mult_dout_tvalid = 1'b0;
        chk("t1_dout_valid", 64'(bus.m_axis_dout_tvalid), 64'h1);
        chk("t1_dout_user",  64'(bus.m_axis_dout_tuser),  64'h1);
        chk("t1_dout_data",  bus.m_axis_dout_tdata,       64'h0000_000B_0000_000A);
        chk("t1_out_back0",  64'(outstanding),            64'h0);
        tick();
        chk("t1_dout_clear", 64'(bus.m_axis_dout_tvalid), 64'h0);

        // All channels requesting: pointer sits at 2 after the channel-1 grant
        bus.s_axis_tvalid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_vec = 4'(1 << seq2[k]);
            chk("t2_grant", 64'(bus.s_axis_tready), 64'(exp_vec));
            tick();
            chk("t2_a_data", 64'(bus.m_mult_a_tdata), 64'(a_of[seq2[k]]));
            chk("t2_b_data", 64'(bus.m_mult_b_tdata), 64'(b_of[seq2[k]]));
        end
        bus.s_axis_tvalid = 4'b0000;
        chk("t2_out5", 64'(outstanding), 64'h5);
        for (int k = 0; k < 5; k++) begin
            bus.s_mult_dout_tvalid = 1'b1;
            bus.s_mult_dout_tdata  = 64'hD0D0_0000_0000_0000 + 64'(k);
            tick();
            chk("t2_dout_valid", 64'(bus.m_axis_dout_tvalid), 64'h1);
            chk("t2_dout_user",  64'(bus.m_axis_dout_tuser),  64'(seq2[k]));
            chk("t2_dout_data",  bus.m_axis_dout_tdata,       64'hD0D0_0000_0000_0000 + 64'(k));
        end
        bus.s_mult_dout_tvalid = 1'b0;
        chk("t2_out0", 64'(outstanding), 64'h0);
        tick();

        // b operand stalled: pointer at 3, channels 3 and 0 requesting
        bus.m_mult_b_tready = 1'b0;
        bus.s_axis_tvalid   = 4'b1001;
        #1;
        chk("t3_grant3", 64'(bus.s_axis_tready), 64'h8);
        tick();
        chk("t3_a_valid1", 64'(bus.m_mult_a_tvalid), 64'h1);
        chk("t3_b_valid1", 64'(bus.m_mult_b_tvalid), 64'h1);
        chk("t3_a_data",   64'(bus.m_mult_a_tdata),  64'(a_of[3]));
        chk("t3_nogrant1", 64'(bus.s_axis_tready),   64'h0);
        tick();
        chk("t3_a_valid2", 64'(bus.m_mult_a_tvalid), 64'h0);
        chk("t3_b_valid2", 64'(bus.m_mult_b_tvalid), 64'h1);
        chk("t3_nogrant2", 64'(bus.s_axis_tready),   64'h0);
        tick();
        chk("t3_a_valid3", 64'(bus.m_mult_a_tvalid), 64'h0);
        chk("t3_b_valid3", 64'(bus.m_mult_b_tvalid), 64'h1);
        chk("t3_nogrant3", 64'(bus.s_axis_tready),   64'h0);
        bus.m_mult_b_tready = 1'b1;
        #1;
        chk("t3_grant0", 64'(bus.s_axis_tready), 64'h1);
        tick();
        bus.s_axis_tvalid = 4'b0000;
        chk("t3_a_data0", 64'(bus.m_mult_a_tdata), 64'(a_of[0]));
        chk("t3_b_data0", 64'(bus.m_mult_b_tdata), 64'(b_of[0]));
        chk("t3_out2",    64'(outstanding),        64'h2);
        tick();
        for (int k = 0; k < 2; k++) begin
            bus.s_mult_dout_tvalid = 1'b1;
            bus.s_mult_dout_tdata  = 64'h0000_0000_3300_0000 + 64'(k);
            tick();
            chk("t3_dout_user", 64'(bus.m_axis_dout_tuser), 64'(seq3[k]));
        end
        bus.s_mult_dout_tvalid = 1'b0;
        tick();

        // Fill to the outstanding limit with the sink stalled; pointer at 1
        bus.m_axis_dout_tready = 1'b0;
        bus.s_axis_tvalid      = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
        end
        chk("t4_out8",     64'(outstanding),         64'h8);
        chk("t4_nogrant",  64'(bus.s_axis_tready),   64'h0);
        tick();
        chk("t4_out8_hold", 64'(outstanding),        64'h8);
        chk("t4_a_idle",    64'(bus.m_mult_a_tvalid), 64'h0);
        bus.s_mult_dout_tvalid = 1'b1;
        bus.s_mult_dout_tdata  = 64'h0000_0000_0000_00EE;
        #1;
        chk("t4_nogrant_retire", 64'(bus.s_axis_tready),      64'h0);
        chk("t4_mdout_ready",    64'(bus.s_mult_dout_tready), 64'h1);
        tick();
        bus.s_mult_dout_tvalid = 1'b0;
        chk("t4_out7",          64'(outstanding),            64'h7);
        chk("t4_dout_valid",    64'(bus.m_axis_dout_tvalid), 64'h1);
        chk("t4_dout_user",     64'(bus.m_axis_dout_tuser),  64'h1);
        chk("t4_regrant",       64'(bus.s_axis_tready),      64'h2);
        chk("t4_mdout_blocked", 64'(bus.s_mult_dout_tready), 64'h0);
        tick();
        chk("t4_out8_again", 64'(outstanding),       64'h8);
        chk("t4_nogrant2",   64'(bus.s_axis_tready), 64'h0);

        // Reset in the middle of traffic
        aresetn = 1'b0;
        #1;
        chk("t5_out0",        64'(outstanding),            64'h0);
        chk("t5_dout_valid",  64'(bus.m_axis_dout_tvalid), 64'h0);
        chk("t5_a_valid",     64'(bus.m_mult_a_tvalid),    64'h0);
        chk("t5_tready",      64'(bus.s_axis_tready),      64'h0);
        chk("t5_mdout_ready", 64'(bus.s_mult_dout_tready), 64'h0);
        tick();
        aresetn                = 1'b1;
        bus.m_axis_dout_tready = 1'b1;
        tick();
        chk("t5_grant0", 64'(bus.s_axis_tready), 64'h1);
        tick();
        bus.s_axis_tvalid = 4'b0000;
        chk("t5_a_data0", 64'(bus.m_mult_a_tdata), 64'(a_of[0]));
        chk("t5_out1",    64'(outstanding),        64'h1);
        tick();
        bus.s_mult_dout_tvalid = 1'b1;
        bus.s_mult_dout_tdata  = 64'h0000_0000_0000_1234;
        tick();
        bus.s_mult_dout_tvalid = 1'b0;
        chk("t5_dout_user", 64'(bus.m_axis_dout_tuser), 64'h0);
        chk("t5_out_back0", 64'(outstanding),           64'h0);
        chk("t5_err_clear", 64'(err_orphan),            64'h0);
        tick();

        // Result with nothing in flight
        bus.s_mult_dout_tvalid = 1'b1;
        bus.s_mult_dout_tdata  = 64'h0000_0000_0000_0BAD;
        tick();
        bus.s_mult_dout_tvalid = 1'b0;
        chk("t6_no_dout", 64'(bus.m_axis_dout_tvalid), 64'h0);
        chk("t6_err",     64'(err_orphan),             64'h1);
        chk("t6_out0",    64'(outstanding),            64'h0);
        tick();
        tick();
        chk("t6_err_sticky", 64'(err_orphan),  64'h1);
        chk("t6_out0_hold",  64'(outstanding), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
